// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// req/ack clients; every access runs IDLE -> ACCESS -> RESP.
module ram_access_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write,
  output logic                  ram_select,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  in_access;
  logic                  in_resp;
  logic                  read_resp;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins.
          grant_d = (req0 && req1) ? ~last_q : req1;
          we_d    = grant_d ? we1    : we0;
          addr_d  = grant_d ? addr1  : addr0;
          wdata_d = grant_d ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (!we_q) begin
          if (grant_q) rdata1_d = ram_data_out;
          else         rdata0_d = ram_data_out;
        end
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data reaches the client straight from the RAM during the ack cycle.
  always_comb begin
    in_access   = (state_q == ACCESS) && !reset;
    in_resp     = (state_q == RESP) && !reset;
    read_resp   = (state_q == RESP) && !we_q;
    busy        = (state_q != IDLE);
    ram_select  = in_access;
    ram_write   = in_access && we_q;
    ram_address = addr_q;
    ram_data_in = wdata_q;
    ack0        = in_resp && !grant_q;
    ack1        = in_resp && grant_q;
    rdata0      = (read_resp && !grant_q) ? ram_data_out : rdata0_q;
    rdata1      = (read_resp && grant_q) ? ram_data_out : rdata1_q;
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: a bench-side RAM, a
// transaction-level reference model and directed client sequences.
module tb_ram_access_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, ram_write, ram_select, busy;
  logic [DW-1:0] rdata0, rdata1, ram_data_in;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_out = '0;
  logic [DW-1:0] ram_mem [8];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_write(ram_write),
    .ram_select(ram_select), .ram_data_out(ram_data_out), .busy(busy)
  );

  // Single-port RAM with registered read data.
  always @(posedge clock) begin
    if (ram_select) begin
      if (ram_write) ram_mem[ram_address] <= ram_data_in;
      else           ram_data_out <= ram_mem[ram_address];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pend counts the remaining cycles of the current
  // transaction (2 = RAM cycle ahead, 1 = ack cycle ahead, 0 = free).
  int            pend = 0;
  bit            started = 0;
  bit            m_g = 0, m_we = 0, m_last = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rd = '0;
  logic [DW-1:0] m_hold [2];
  logic [DW-1:0] m_mem [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    m_hold[0] = '0;
    m_hold[1] = '0;
  end

  always @(posedge clock) begin
    if (reset) begin
      pend = 0;
      m_last = 1;
      m_hold[0] = '0;
      m_hold[1] = '0;
      started = 1;
    end else begin
      case (pend)
        0: if (req0 || req1) begin
          m_g     = (req0 && req1) ? !m_last : req1;
          m_we    = m_g ? we1 : we0;
          m_addr  = m_g ? addr1 : addr0;
          m_wdata = m_g ? wdata1 : wdata0;
          pend    = 2;
        end
        2: begin
          if (m_we) m_mem[m_addr] = m_wdata;
          else      m_rd = m_mem[m_addr];
          pend = 1;
        end
        default: begin
          if (!m_we) m_hold[m_g] = m_rd;
          m_last = m_g;
          pend   = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (started) begin
      checkOutput("busy", busy, pend != 0);
      checkOutput("ram_select", ram_select, pend == 2 && !reset);
      checkOutput("ram_write", ram_write, pend == 2 && !reset && m_we);
      checkOutput("ack0", ack0, pend == 1 && !reset && !m_g);
      checkOutput("ack1", ack1, pend == 1 && !reset && m_g);
      checkOutput("dual_ack", ack0 & ack1, 0);
      checkOutput("rdata0", rdata0, (pend == 1 && !m_we && !m_g) ? m_rd : m_hold[0]);
      checkOutput("rdata1", rdata1, (pend == 1 && !m_we && m_g) ? m_rd : m_hold[1]);
      if (pend == 2) begin
        checkOutput("ram_address", ram_address, m_addr);
        if (m_we) checkOutput("ram_data_in", ram_data_in, m_wdata);
      end
    end
  end

  // One complete access on a single port; lat counts rising edges to the ack.
  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
    bit seen = 0;
    lat = 0;
    rd  = '0;
    if (port == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (port == 0 && ack0) begin seen = 1; rd = rdata0; end
      if (port == 1 && ack1) begin seen = 1; rd = rdata1; end
    end
    if (!seen) checkOutput("ack_timeout", lat, 2);
    @(posedge clock); #1;
    if (port == 0) req0 = 0; else req1 = 0;
  endtask

  int            ack_port[$];
  int            ack_time[$];
  logic [DW-1:0] last_rd0;

  // Both requests are already set up; collect n_acks acks in order.
  task automatic runBoth(input int n_acks, input bit hold);
    int got = 0;
    bit d0 = 0, d1 = 0;
    ack_port.delete();
    ack_time.delete();
    for (int n = 1; n <= 60 && got < n_acks; n++) begin
      @(posedge clock); #1;
      if (d0 && !hold) req0 = 0;
      if (d1 && !hold) req1 = 0;
      d0 = 0;
      d1 = 0;
      @(negedge clock);
      if (ack0) begin ack_port.push_back(0); ack_time.push_back(n); last_rd0 = rdata0; d0 = 1; got++; end
      if (ack1) begin ack_port.push_back(1); ack_time.push_back(n); d1 = 1; got++; end
    end
    if (got < n_acks) checkOutput("ack_timeout", got, n_acks);
    @(posedge clock); #1;
    req0 = 0;
    req1 = 0;
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  initial begin
    int            lat;
    int            n0;
    logic [DW-1:0] rd;
    bit            seen;

    $display("[TB] starting");
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (5) @(negedge clock);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_rdata0", rdata0, 0);
    checkOutput("idle_rdata1", rdata1, 0);

    applyStimulus(0, 1, 3'd3, 8'hA5, lat, rd);
    checkOutput("wr_latency", lat, 2);
    applyStimulus(0, 0, 3'd3, 8'h00, lat, rd);
    checkOutput("rd_latency", lat, 2);
    checkOutput("rd_addr3", rd, 8'hA5);

    doReset();
    req0 = 1; we0 = 0; addr0 = 3'd3;
    req1 = 1; we1 = 1; addr1 = 3'd5; wdata1 = 8'h3C;
    runBoth(2, 0);
    checkOutput("cont_first_port", ack_port[0], 0);
    checkOutput("cont_first_time", ack_time[0], 2);
    checkOutput("cont_second_port", ack_port[1], 1);
    checkOutput("cont_second_time", ack_time[1], 5);
    checkOutput("cont_rdata0", last_rd0, 8'hA5);
    applyStimulus(0, 0, 3'd5, 8'h00, lat, rd);
    checkOutput("rd_addr5", rd, 8'h3C);

    doReset();
    req0 = 1; we0 = 0; addr0 = 3'd3;
    req1 = 1; we1 = 0; addr1 = 3'd5;
    runBoth(12, 1);
    n0 = 0;
    for (int i = 0; i < ack_port.size(); i++) begin
      checkOutput("rr_port", ack_port[i], i % 2);
      checkOutput("rr_time", ack_time[i], 2 + 3 * i);
      if (ack_port[i] == 0) n0++;
    end
    checkOutput("rr_count0", n0, 6);
    checkOutput("rr_count1", ack_port.size() - n0, 6);

    applyStimulus(1, 1, 3'd2, 8'h11, lat, rd);
    req1 = 1; we1 = 1; addr1 = 3'd2; wdata1 = 8'hFF;
    @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    checkOutput("rst_select", ram_select, 0);
    checkOutput("rst_ack1", ack1, 0);
    @(posedge clock); #1;
    reset = 0;
    req1 = 0;
    repeat (4) begin
      @(negedge clock);
      checkOutput("rst_no_ack1", ack1, 0);
    end
    applyStimulus(1, 0, 3'd2, 8'h00, lat, rd);
    checkOutput("rst_rd_addr2", rd, 8'h11);

    applyStimulus(0, 1, 3'd1, 8'h5A, lat, rd);
    applyStimulus(0, 1, 3'd6, 8'h66, lat, rd);
    req0 = 1; we0 = 0; addr0 = 3'd1;
    @(posedge clock); #1;
    addr0 = 3'd6;
    seen = 0;
    rd = '0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (ack0) begin seen = 1; rd = rdata0; end
      else @(posedge clock);
    end
    checkOutput("stab_ack_seen", seen, 1);
    checkOutput("stab_rdata0", rd, 8'h5A);
    @(posedge clock); #1;
    req0 = 0;
    repeat (3) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
